fir_transposed_pipe: RTL and testbench

//  Parametrised N-tap transposed-form FIR filter for signed sample streams. Has
//  run-time programmable coefficients (shadow bank plus atomic commit), valid-qualified
//  in/out, round-half-up output scaling, output saturation and a sticky overflow flag.

---
 rtl/fir_transposed_pipe.sv | 107 ++++++++++
 tb/tb_fir_transposed_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_transposed_pipe.sv
// Transposed-form N-tap FIR with shadow/active coefficient banks, round-half-up
// output scaling, output saturation and a sticky saturation flag.
module fir_transposed_pipe #(
  parameter  int DW    = 16,
  parameter  int CW    = 16,
  parameter  int NTAPS = 8,
  parameter  int SHIFT = 14,
  parameter  int OW    = 16,
  localparam int AW    = $clog2(NTAPS),
  localparam int ACCW  = DW + CW + $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          clear,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  input  logic          coef_commit,
  output logic          sat_flag,
  input  logic          sat_clr
);

  localparam logic signed [CW-1:0]   H_ID = CW'(1) << SHIFT;
  localparam logic signed [ACCW-1:0] RND  = ACCW'(1) << (SHIFT - 1);
  localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [AW:0]            NT   = NTAPS[AW:0];

  logic signed [CW-1:0]   shadow_q [NTAPS];
  logic signed [CW-1:0]   active_q [NTAPS];
  // r_q[j] holds partial sum r[j+1] of the transposed chain.
  logic signed [ACCW-1:0] r_q [NTAPS-1];
  logic signed [ACCW-1:0] r_d [NTAPS-1];
  logic signed [ACCW-1:0] prod [NTAPS];
  logic signed [ACCW-1:0] x_ext, acc, rnd, y;
  logic [OW-1:0]          out_data_d;
  logic                   out_valid_d, sat_flag_d;
  logic                   accept, sat_hi, sat_lo;

  // Input is a plain valid strobe with no back-pressure: a sample is taken on any
  // cycle with in_valid=1 and clear=0; out_valid pulses once per taken sample.
  assign accept = in_valid & ~clear;

  always_comb begin
    x_ext = {{(ACCW-DW){in_data[DW-1]}}, in_data};
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = x_ext * {{(ACCW-CW){active_q[k][CW-1]}}, active_q[k]};
    end
    acc    = prod[0] + r_q[0];
    rnd    = acc + RND;
    y      = rnd >>> SHIFT;
    sat_hi = (y > OMAX);
    sat_lo = (y < OMIN);
  end

  always_comb begin
    r_d         = r_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    sat_flag_d  = sat_flag;
    if (clear) begin
      for (int j = 0; j < NTAPS-1; j++) r_d[j] = '0;
    end else if (accept) begin
      for (int j = 0; j < NTAPS-2; j++) r_d[j] = prod[j+1] + r_q[j+1];
      r_d[NTAPS-2] = prod[NTAPS-1];
      out_valid_d  = 1'b1;
      if (sat_hi)      out_data_d = OMAX[OW-1:0];
      else if (sat_lo) out_data_d = OMIN[OW-1:0];
      else             out_data_d = y[OW-1:0];
    end
    // A fresh clamp outranks a same-cycle clear request.
    if (sat_clr) sat_flag_d = 1'b0;
    if (accept && (sat_hi || sat_lo)) sat_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NTAPS-1; j++) r_q[j] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      r_q       <= r_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      sat_flag  <= sat_flag_d;
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == 0) ? H_ID : '0;
        active_q[k] <= (k == 0) ? H_ID : '0;
      end
    end else begin
      if (coef_we && ({1'b0, coef_addr} < NT)) shadow_q[coef_addr] <= coef_wdata;
      if (coef_commit) active_q <= shadow_q;
    end
  end

endmodule

// File: tb/tb_fir_transposed_pipe.sv
// Randomised and directed bench for fir_transposed_pipe, checked against a
// sample-history reference model of the transposed FIR.
module tb_fir_transposed_pipe;
  localparam int DW = 16, CW = 16, NTAPS = 8, SHIFT = 14, OW = 16;
  localparam int AW = $clog2(NTAPS);
  localparam longint OMAX = (64'sd1 <<< (OW-1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          clear = 1'b0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          coef_commit = 1'b0;
  logic          sat_flag;
  logic          sat_clr = 1'b0;

  fir_transposed_pipe #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .clear(clear), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int     vectors = 0;
  int     miscompares = 0;
  int     valid_cnt = 0;
  int     accept_cnt = 0;
  logic [OW-1:0] exp_q[$];
  longint got_q[$];

  longint hx [NTAPS];           // last NTAPS accepted samples, newest first
  longint hh [NTAPS][NTAPS];    // active coefficients seen by each of those samples
  longint sh [NTAPS];
  longint act [NTAPS];
  longint exp_data;
  bit     exp_valid, exp_sat;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      hx[k]  = 0;
      sh[k]  = (k == 0) ? (64'sd1 <<< SHIFT) : 0;
      act[k] = sh[k];
      for (int j = 0; j < NTAPS; j++) hh[k][j] = 0;
    end
    exp_data = 0; exp_valid = 0; exp_sat = 0;
  endtask

  // Output n = sum over k of x[n-k] * (coefficient k active when x[n-k] arrived).
  task automatic model_update(input bit v, input longint x, input bit clr, input bit we,
                              input int addr, input longint wd, input bit cm, input bit sc);
    longint acc, y;
    bit sat;
    sat = 0;
    exp_valid = 0;
    if (clr) begin
      for (int k = 0; k < NTAPS; k++) hx[k] = 0;
    end else if (v) begin
      for (int k = NTAPS-1; k > 0; k--) begin
        hx[k] = hx[k-1];
        hh[k] = hh[k-1];
      end
      hx[0] = x;
      hh[0] = act;
      acc = 0;
      for (int k = 0; k < NTAPS; k++) acc += hx[k] * hh[k][k];
      y = (acc + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
      if (y > OMAX) begin y = OMAX; sat = 1; end
      else if (y < OMIN) begin y = OMIN; sat = 1; end
      exp_data  = y;
      exp_valid = 1;
      accept_cnt++;
    end
    if (sat) exp_sat = 1;
    else if (sc) exp_sat = 0;
    if (cm) act = sh;
    if (we && addr < NTAPS) sh[addr] = wd;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input int x, input bit clr, input bit we,
                      input int addr, input int wd, input bit cm, input bit sc);
    @(negedge clk);
    in_valid = v; in_data = DW'(x); clear = clr; coef_we = we;
    coef_addr = AW'(addr); coef_wdata = CW'(wd); coef_commit = cm; sat_clr = sc;
    @(posedge clk);
    model_update(v, longint'(x), clr, we, addr, longint'(wd), cm, sc);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    check("out_data", $signed(out_data), exp_data);
    check("sat_flag", {63'd0, sat_flag}, {63'd0, exp_sat});
    if (out_valid) begin
      valid_cnt++;
      got_q.push_back($signed(out_data));
    end
  endtask

  task automatic sample(input int x);
    step(1, x, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    step(0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic load_coefs(input int c [NTAPS]);
    for (int k = 0; k < NTAPS; k++) step(0, 0, 0, 1, k, c[k], 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 0; clear = 0; coef_we = 0; coef_commit = 0; sat_clr = 0;
    model_reset();
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    check("rst_out_data", $signed(out_data), 64'sd0);
    check("rst_sat_flag", {63'd0, sat_flag}, 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c [NTAPS];
    int base_v, base_a, gap;
    logic signed [CW-1:0] rc;
    logic signed [DW-1:0] rx;

    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();

    // identity passthrough after reset
    sample(1234); check("s1_y0", $signed(out_data), 64'sd1234);
    sample(0);    check("s1_y1", $signed(out_data), 64'sd0);
    sample(0);
    idle();       check("s1_pulse", {63'd0, out_valid}, 64'sd0);

    // three-tap impulse response
    c = '{4096, 8192, 12288, 0, 0, 0, 0, 0};
    load_coefs(c);
    flush();
    sample(400); check("s2_y0", $signed(out_data), 64'sd100);
    sample(0);   check("s2_y1", $signed(out_data), 64'sd200);
    sample(0);   check("s2_y2", $signed(out_data), 64'sd300);
    sample(0);   check("s2_y3", $signed(out_data), 64'sd0);

    // same response with idle gaps between samples
    flush();
    got_q.delete();
    base_v = valid_cnt; base_a = accept_cnt;
    exp_q = '{16'd100, 16'd200, 16'd300, 16'd0};
    for (int i = 0; i < 4; i++) begin
      sample(i == 0 ? 400 : 0);
      gap = $urandom_range(0, 3);
      repeat (gap) idle();
    end
    check("s3_count", got_q.size(), 64'sd4);
    check("s3_valids", valid_cnt - base_v, accept_cnt - base_a);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("s3_seq", got_q[i], $signed(exp_q[i]));

    // rounding, half toward +inf
    c = '{8192, 0, 0, 0, 0, 0, 0, 0};
    load_coefs(c);
    sample(3);  check("rnd_p3", $signed(out_data), 64'sd2);
    sample(-3); check("rnd_m3", $signed(out_data), -64'sd1);
    sample(1);  check("rnd_p1", $signed(out_data), 64'sd1);
    sample(-1); check("rnd_m1", $signed(out_data), 64'sd0);

    // clear wins over a same-cycle sample
    step(1, 5000, 1, 0, 0, 0, 0, 0);
    check("clr_drop", {63'd0, out_valid}, 64'sd0);

    // saturation both ways and sticky flag
    c = '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383};
    load_coefs(c);
    flush();
    repeat (9) sample(30000);
    check("sat_hi", $signed(out_data), 64'sd32767);
    check("sat_set", {63'd0, sat_flag}, 64'sd1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("sat_clr", {63'd0, sat_flag}, 64'sd0);
    repeat (9) sample(-30000);
    check("sat_lo", $signed(out_data), -64'sd32768);
    step(1, -30000, 0, 0, 0, 0, 0, 1);
    check("sat_set_wins", {63'd0, sat_flag}, 64'sd1);

    // clear mid-stream removes history
    c = '{4096, 8192, 12288, 0, 0, 0, 0, 0};
    load_coefs(c);
    repeat (5) sample(int'($urandom_range(0, 20000)) - 10000);
    flush();
    sample(400); check("clr_y0", $signed(out_data), 64'sd100);
    sample(0);   check("clr_y1", $signed(out_data), 64'sd200);
    sample(0);   check("clr_y2", $signed(out_data), 64'sd300);

    // reset mid-stream restores identity coefficients
    sample(777);
    apply_reset();
    sample(1234); check("rst_identity", $signed(out_data), 64'sd1234);

    // write in the commit cycle only reaches the shadow
    step(0, 0, 0, 1, 1, 8192, 1, 0);
    flush();
    sample(400); check("wc_y0", $signed(out_data), 64'sd400);
    sample(0);   check("wc_y1", $signed(out_data), 64'sd0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    flush();
    sample(400); check("wc2_y0", $signed(out_data), 64'sd400);
    sample(0);   check("wc2_y1", $signed(out_data), 64'sd200);

    // randomized traffic including commits mid-stream (transition region modelled)
    for (int i = 0; i < 2000; i++) begin
      rc = CW'($urandom);
      rx = DW'($urandom);
      step($urandom_range(0, 3) != 0, int'(rx), $urandom_range(0, 40) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, NTAPS-1), int'(rc),
           $urandom_range(0, 30) == 0, $urandom_range(0, 20) == 0);
    end
    step(1, 16384, 0, 0, 0, 0, 0, 0);
    flush();
    repeat (3) sample(int'($urandom_range(0, 2000)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
